// File: rtl/alu_operand_pkg.sv
// Shared encodings for immediate format and ALU operand source selects.
// Used by the decoder, the control unit and the operand stage.
package alu_operand_pkg;

  // Immediate formats; codes 6 and 7 are reserved and yield zero.
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  // Operand A sources; code 3 is reserved and yields zero.
  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  // Operand B sources.
  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  // Architectural zero register; reads of it are never forwarded.
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts and sign-extends the RISC-V immediate
// selected by imm_fmt from a raw 32-bit instruction. Purely combinational.
module imm_gen
  import alu_operand_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // Assemble the 32-bit sign-extended immediate for each format.
  always_comb begin
    imm32 = '0;
    case (imm_fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Widen to XLEN, replicating bit 31 (which is always instr[31] or zero).
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: builds the immediate, resolves rs1/rs2 through the
// forwarding network, selects operands A and B, and registers everything
// as the ID/EX operand register with flush and stall control.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned REG_AW  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [31:0]               instr,
  input  logic [XLEN-1:0]           pc,
  input  logic [2:0]                imm_fmt,
  input  logic [1:0]                src_a_sel,
  input  logic                      src_b_sel,
  input  logic [REG_AW-1:0]         rs1_addr,
  input  logic [REG_AW-1:0]         rs2_addr,
  input  logic [XLEN-1:0]           rs1_data,
  input  logic [XLEN-1:0]           rs2_data,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic                      ex_valid,
  output logic [XLEN-1:0]           ex_op_a,
  output logic [XLEN-1:0]           ex_op_b,
  output logic [XLEN-1:0]           ex_store_data,
  output logic [XLEN-1:0]           ex_imm,
  output logic [1:0]                ex_fwd_hit
);

  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rs1_hit;
  logic            rs2_hit;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .instr  (instr),
    .imm_fmt(imm_fmt),
    .imm    (imm)
  );

  // One priority forwarding selector per source operand (0 = rs1, 1 = rs2).
  for (genvar op = 0; op < 2; op++) begin : g_fwd
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   rf_data;
    logic [XLEN-1:0]   value;
    logic              hit;

    assign addr    = (op == 0) ? rs1_addr : rs2_addr;
    assign rf_data = (op == 0) ? rs1_data : rs2_data;

    // Scan oldest to youngest so the lowest matching index wins.
    always_comb begin
      value = rf_data;
      hit   = 1'b0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_valid[k] && (fwd_rd[k*REG_AW +: REG_AW] == addr) &&
            (addr != REG_AW'(ZERO_REG))) begin
          value = fwd_data[k*XLEN +: XLEN];
          hit   = 1'b1;
        end
      end
    end
  end

  assign rs1_val = g_fwd[0].value;
  assign rs2_val = g_fwd[1].value;
  assign rs1_hit = g_fwd[0].hit;
  assign rs2_hit = g_fwd[1].hit;

  // Operand A/B source muxes; reserved A select reads as zero.
  always_comb begin
    op_a = '0;
    case (src_a_sel)
      SRC_A_RS1:  op_a = rs1_val;
      SRC_A_PC:   op_a = pc;
      SRC_A_ZERO: op_a = '0;
      default:    op_a = '0;
    endcase
    op_b = (src_b_sel == SRC_B_IMM) ? imm : rs2_val;
  end

  // ID/EX register: reset and flush clear, stall holds, otherwise load.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid      <= 1'b0;
      ex_op_a       <= '0;
      ex_op_b       <= '0;
      ex_store_data <= '0;
      ex_imm        <= '0;
      ex_fwd_hit    <= '0;
    end else if (!stall) begin
      ex_valid      <= id_valid;
      ex_op_a       <= op_a;
      ex_op_b       <= op_b;
      ex_store_data <= rs2_val;
      ex_imm        <= imm;
      ex_fwd_hit    <= {rs2_hit, rs1_hit};
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage (XLEN=64, NUM_FWD=2): the driver
// pushes hand-computed expectations, the monitor pops and compares them.
module tb_alu_operand_stage;

  logic         clk = 1'b0;
  logic         rst, stall, flush, id_valid;
  logic [31:0]  instr;
  logic [63:0]  pc;
  logic [2:0]   imm_fmt;
  logic [1:0]   src_a_sel;
  logic         src_b_sel;
  logic [4:0]   rs1_addr, rs2_addr;
  logic [63:0]  rs1_data, rs2_data;
  logic [1:0]   fwd_valid;
  logic [9:0]   fwd_rd;
  logic [127:0] fwd_data;
  logic         ex_valid;
  logic [63:0]  ex_op_a, ex_op_b, ex_store_data, ex_imm;
  logic [1:0]   ex_fwd_hit;

  localparam logic [63:0] ONES = '1;

  typedef struct {
    int          due;
    string       name;
    logic        v;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] st;
    logic [63:0] imm;
    logic [1:0]  hit;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  alu_operand_stage #(
    .XLEN   (64),
    .NUM_FWD(2),
    .REG_AW (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .id_valid     (id_valid),
    .instr        (instr),
    .pc           (pc),
    .imm_fmt      (imm_fmt),
    .src_a_sel    (src_a_sel),
    .src_b_sel    (src_b_sel),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .ex_valid     (ex_valid),
    .ex_op_a      (ex_op_a),
    .ex_op_b      (ex_op_b),
    .ex_store_data(ex_store_data),
    .ex_imm       (ex_imm),
    .ex_fwd_hit   (ex_fwd_hit)
  );

  always #5 clk = ~clk;

  // Monitor: count edges, sample 1ns after each, compare due expectations.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (ex_valid !== e.v || ex_op_a !== e.a || ex_op_b !== e.b ||
          ex_store_data !== e.st || ex_imm !== e.imm || ex_fwd_hit !== e.hit) begin
        errors++;
        $display("FAIL %s: got v=%0b a=%h b=%h st=%h imm=%h hit=%b, want v=%0b a=%h b=%h st=%h imm=%h hit=%b",
                 e.name, ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_imm, ex_fwd_hit,
                 e.v, e.a, e.b, e.st, e.imm, e.hit);
      end
    end
  end

  task automatic set_fwd(input int k, input logic v, input logic [4:0] rd,
                         input logic [63:0] d);
    fwd_valid[k]       = v;
    fwd_rd[k*5 +: 5]   = rd;
    fwd_data[k*64 +: 64] = d;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
    instr = '0; pc = '0; imm_fmt = 3'd0; src_a_sel = 2'd0; src_b_sel = 1'b0;
    rs1_addr = '0; rs2_addr = '0; rs1_data = '0; rs2_data = '0;
    fwd_valid = '0; fwd_rd = '0; fwd_data = '0;
  endtask

  task automatic randomize_inputs();
    id_valid  = 1'($urandom);
    instr     = $urandom;
    pc        = {$urandom, $urandom};
    imm_fmt   = 3'($urandom_range(0, 7));
    src_a_sel = 2'($urandom_range(0, 3));
    src_b_sel = 1'($urandom);
    rs1_addr  = 5'($urandom);
    rs2_addr  = 5'($urandom);
    rs1_data  = {$urandom, $urandom};
    rs2_data  = {$urandom, $urandom};
    fwd_valid = 2'($urandom);
    fwd_rd    = 10'($urandom);
    fwd_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Queue the expectation for the next edge, then move to the next negedge.
  task automatic push(input string name, input logic v, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] st,
                      input logic [63:0] imm, input logic [1:0] hit);
    exp_t e;
    e.due = cyc + 1; e.name = name; e.v = v; e.a = a; e.b = b;
    e.st = st; e.imm = imm; e.hit = hit;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    randomize_inputs();
    rst = 1'b1;
    @(negedge clk);

    // Reset, including reset asserted during stall and flush.
    randomize_inputs(); rst = 1'b1;
    push("reset0", 0, 0, 0, 0, 0, 2'b00);
    randomize_inputs(); rst = 1'b1; stall = 1'b1; flush = 1'b1;
    push("reset1", 0, 0, 0, 0, 0, 2'b00);

    // Immediate formats.
    clear_inputs();
    rs1_addr = 5'd3; rs1_data = 64'h100; rs2_addr = 5'd4; rs2_data = 64'h200;
    src_b_sel = 1'b1; imm_fmt = 3'd1; instr = 32'hFFF00093;
    push("imm_i_first_load", 1, 64'h100, ONES, 64'h200, ONES, 2'b00);
    imm_fmt = 3'd2; instr = 32'h0020B423;
    push("imm_s", 1, 64'h100, 64'd8, 64'h200, 64'd8, 2'b00);
    imm_fmt = 3'd4; instr = 32'h800000B7; src_a_sel = 2'd1; pc = 64'h8000_0000_0000_1000;
    push("imm_u_pc", 1, 64'h8000_0000_0000_1000, 64'hFFFF_FFFF_8000_0000, 64'h200,
         64'hFFFF_FFFF_8000_0000, 2'b00);
    imm_fmt = 3'd3; instr = 32'hFE000EE3; src_a_sel = 2'd2;
    push("imm_b_neg", 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h200, 64'hFFFF_FFFF_FFFF_FFFC, 2'b00);
    imm_fmt = 3'd5; instr = 32'hFFFFF0EF; src_a_sel = 2'd3;
    push("imm_j_neg", 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h200, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00);
    instr = 32'h0010006F; src_a_sel = 2'd0; src_b_sel = 1'b0;
    push("imm_j_bit11", 1, 64'h100, 64'h200, 64'h200, 64'h800, 2'b00);
    imm_fmt = 3'd0; instr = 32'hFFF00093; src_b_sel = 1'b1;
    push("imm_none", 1, 64'h100, 0, 64'h200, 0, 2'b00);
    imm_fmt = 3'd7;
    push("imm_reserved", 1, 64'h100, 0, 64'h200, 0, 2'b00);

    // Forwarding priority.
    clear_inputs();
    rs1_addr = 5'd5; rs1_data = 64'h11; rs2_addr = 5'd4; rs2_data = 64'h200;
    set_fwd(0, 1, 5'd5, 64'hAA); set_fwd(1, 1, 5'd5, 64'hBB);
    push("fwd_youngest", 1, 64'hAA, 64'h200, 64'h200, 0, 2'b01);
    set_fwd(0, 0, 5'd5, 64'hAA);
    push("fwd_older", 1, 64'hBB, 64'h200, 64'h200, 0, 2'b01);
    set_fwd(1, 0, 5'd5, 64'hBB);
    push("fwd_none", 1, 64'h11, 64'h200, 64'h200, 0, 2'b00);
    set_fwd(0, 1, 5'd6, 64'hAA); set_fwd(1, 1, 5'd5, 64'hBB); rs2_addr = 5'd6;
    push("fwd_split", 1, 64'hBB, 64'hAA, 64'hAA, 0, 2'b11);

    // x0 is never forwarded.
    clear_inputs();
    rs1_addr = 5'd0; rs1_data = 64'h55; rs2_addr = 5'd0; rs2_data = 64'h0;
    set_fwd(0, 1, 5'd0, 64'hDEAD); set_fwd(1, 1, 5'd0, 64'hBEEF);
    push("x0_guard", 1, 64'h55, 0, 0, 0, 2'b00);

    // Store: B takes the immediate, store data takes forwarded rs2.
    clear_inputs();
    rs1_addr = 5'd1; rs1_data = 64'h40; rs2_addr = 5'd2; rs2_data = 64'h9;
    set_fwd(1, 1, 5'd2, 64'h1234); src_b_sel = 1'b1; imm_fmt = 3'd2; instr = 32'h0020B423;
    push("store_ops", 1, 64'h40, 64'd8, 64'h1234, 64'd8, 2'b10);
    id_valid = 1'b0;
    push("data_loads_invalid", 0, 64'h40, 64'd8, 64'h1234, 64'd8, 2'b10);

    // Stall holds, stall+flush clears, release loads.
    clear_inputs();
    rs1_addr = 5'd7; rs1_data = 64'h7777; rs2_addr = 5'd8; rs2_data = 64'h8888;
    src_b_sel = 1'b1; imm_fmt = 3'd1; instr = 32'h00500093;
    push("op_x", 1, 64'h7777, 64'd5, 64'h8888, 64'd5, 2'b00);
    for (int i = 0; i < 3; i++) begin
      randomize_inputs(); stall = 1'b1;
      push("stall_hold", 1, 64'h7777, 64'd5, 64'h8888, 64'd5, 2'b00);
    end
    randomize_inputs(); stall = 1'b1; flush = 1'b1;
    push("stall_flush", 0, 0, 0, 0, 0, 2'b00);
    randomize_inputs(); stall = 1'b1; flush = 1'b0;
    push("stall_after_flush", 0, 0, 0, 0, 0, 2'b00);
    clear_inputs();
    rs1_addr = 5'd9; rs1_data = 64'h99; rs2_addr = 5'd10; rs2_data = 64'hA0;
    set_fwd(0, 1, 5'd9, 64'hF0F0);
    push("op_y_release", 1, 64'hF0F0, 64'hA0, 64'hA0, 0, 2'b01);
    flush = 1'b1;
    push("flush_only", 0, 0, 0, 0, 0, 2'b00);
    flush = 1'b0;
    push("op_y_again", 1, 64'hF0F0, 64'hA0, 64'hA0, 0, 2'b01);
    rst = 1'b1; stall = 1'b1;
    push("rst_mid_stall", 0, 0, 0, 0, 0, 2'b00);
    rst = 1'b0;
    push("hold_after_rst", 0, 0, 0, 0, 0, 2'b00);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
